pipe_ifid_buf: RTL and testbench
================================

Name: pipe_ifid_buf

Overview:
- Elastic IF→ID boundary buffer: a small FIFO between the instruction-fetch stage and the decode stage.
- Accepts {pc, inst} packets from IF with a valid/ready handshake and presents them to ID in order.
- Breaks the combinational ready path from ID back into IF.
- Discards all buffered packets on a pipeline flush.

Parameters:
- DEPTH, 2, number of entries; power of two, ≥2.
- PTR_W, $clog2(DEPTH), pointer width (derived; not overridden).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset.
- flush_i  input  1  redirect from EX/WB; drop all buffered and incoming packets.
- if_valid_i  input  1  IF has a packet this cycle.
- ifToId_i  input  ifToId_t (64)  {pc[31:0], inst[31:0]} from IF.
- if_ready_o  output  1  buffer can accept a packet; drives IF's id_ready_i.
- id_valid_o  output  1  head packet valid for ID.
- ifToId_o  output  ifToId_t (64)  head packet {pc, inst}.
- id_ready_i  input  1  ID accepts the head packet this cycle.

Behaviour:
- Reset: rst_i, asynchronous, active-high; clock clk_i.
  - Reset clears rd_ptr, wr_ptr and count to 0, and all entry storage to 0.
  - After reset: id_valid_o=0, if_ready_o=1, ifToId_o=0.
- Storage: DEPTH-entry register array plus rd_ptr and wr_ptr (PTR_W bits) and count (PTR_W+1 bits).
  - Pointers wrap modulo DEPTH by natural overflow.
- if_ready_o = (count != DEPTH).
  - Depends only on registered state; no combinational path from id_ready_i or flush_i.
- id_valid_o = (count != 0) & ~flush_i.
- ifToId_o = entry[rd_ptr], driven combinationally from registers.
  - Holds its value while id_valid_o=1 and id_ready_i=0.
- push = if_valid_i & if_ready_o & ~flush_i.
- pop = id_valid_o & id_ready_i.
- Normal cycle, no flush:
  - On push: write entry[wr_ptr], then wr_ptr+1.
  - On pop: rd_ptr+1.
  - count += push − pop.
- Simultaneous push and pop:
  - When full: if_ready_o=0, so no push; pop frees a slot, and if_ready_o=1 next cycle.
  - When empty: id_valid_o=0, so no pop; pushed data appears next cycle.
  - No same-cycle bypass: latency from IF to ID is exactly 1 cycle.
- Throughput: 1 packet/cycle sustained while id_ready_i stays high.
- Flush (flush_i=1):
  - Same cycle: id_valid_o forced 0; push and pop suppressed.
  - Next edge: rd_ptr=wr_ptr=count=0. Storage is not cleared.
  - Cycle after flush: id_valid_o=0, if_ready_o=1.
- Flush takes priority over push and pop in every state, including full.
- A packet offered by IF during flush is lost. This is intended: IF masks its own valid during flush.
- Reset asserted mid-operation discards everything asynchronously, identical to post-reset state.
- Ordering: strict FIFO; no entry is dropped or duplicated without a flush.
- Assertions for the bench:
  - Never push when count==DEPTH.
  - Never pop when count==0.
  - count ≤ DEPTH.

Decomposition:
- liang_pkg holds:
  - pc_t, inst_t (32-bit each).
  - ifToId_t struct {pc_t pc; inst_t inst;}.
  - IFID_DEPTH = 2 constant used at instantiation.
- No sub-module needed: pointer/count logic and storage live in one module.
- Instantiated between pipe_ifu and the decode stage.

Test Plan:
- Reset release, idle inputs → id_valid_o=0, if_ready_o=1, ifToId_o=0 in first cycle after reset.
- Single push {pc=0x80000000, inst=0x00000413}, id_ready_i=1 → next cycle id_valid_o=1 with that packet; following cycle id_valid_o=0.
- Back-pressure: id_ready_i=0, push pc 0x80000000, 0x80000004, 0x80000008 on consecutive cycles:
  - Third push is refused, with if_ready_o=0 after 2 accepts.
  - Raising id_ready_i drains 0x80000000 then 0x80000004 in order.
  - if_ready_o returns to 1 one cycle after the first pop.
- Streaming: if_valid_i=1 and id_ready_i=1 for 10 cycles, pc incrementing by 4 from 0x80000000 → ID receives 10 packets back-to-back, 1-cycle latency, no bubbles.
- Flush when full (count=2) with if_valid_i=1, pc=0x8000000C:
  - Same cycle: id_valid_o=0.
  - Next cycle: count=0, id_valid_o=0, if_ready_o=1; 0x8000000C is never delivered.
  - A push of pc=0x80000100 on the following cycle appears next at ID.
- Async reset mid-stream (count=1, rd_ptr=1) → outputs return to reset values without a clock edge; a subsequent push of 0x80000000 is delivered normally.

Source files
------------

// File: rtl/liang_pkg.sv
// Shared types for the IF->ID boundary of the liang pipeline.
package liang_pkg;

  typedef logic [31:0] pc_t;
  typedef logic [31:0] inst_t;

  typedef struct packed {
    pc_t   pc;
    inst_t inst;
  } ifToId_t;

  localparam int IFID_DEPTH = 2;

endpackage

// File: rtl/pipe_ifid_buf.sv
// Elastic IF->ID buffer: small in-order FIFO with a registered ready toward IF
// and a flush that empties it in one cycle.
module pipe_ifid_buf
  import liang_pkg::*;
#(
  parameter int DEPTH = IFID_DEPTH
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    flush_i,
  input  logic    if_valid_i,
  input  ifToId_t ifToId_i,
  output logic    if_ready_o,
  output logic    id_valid_o,
  output ifToId_t ifToId_o,
  input  logic    id_ready_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  ifToId_t          entry_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;

  // Ready comes only from registered state, so ID's ready never reaches IF.
  assign if_ready_o = (count_q != FULL_CNT);
  assign id_valid_o = (count_q != '0) & ~flush_i;
  assign ifToId_o   = entry_q[rd_ptr_q];

  assign push = if_valid_i & if_ready_o & ~flush_i;
  assign pop  = id_valid_o & id_ready_i;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latch).
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: storage is reset as well, so the head output reads zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push) entry_q[wr_ptr_q] <= ifToId_i;
    end
  end

endmodule

// File: tb/tb_pipe_ifid_buf.sv
// Directed bench for pipe_ifid_buf: vector table plus hand-written flush/reset sequences.
module tb_pipe_ifid_buf;
  import liang_pkg::*;

  logic    clk_i = 1'b0;
  logic    rst_i;
  logic    flush_i;
  logic    if_valid_i;
  ifToId_t ifToId_i;
  logic    if_ready_o;
  logic    id_valid_o;
  ifToId_t ifToId_o;
  logic    id_ready_i;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_ifid_buf #(.DEPTH(IFID_DEPTH)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .if_valid_i (if_valid_i),
    .ifToId_i   (ifToId_i),
    .if_ready_o (if_ready_o),
    .id_valid_o (id_valid_o),
    .ifToId_o   (ifToId_o),
    .id_ready_i (id_ready_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (dut.count_q <= 2) else $error("count exceeds depth");
      assert (!(dut.push && dut.count_q == 2)) else $error("push while full");
      assert (!(dut.pop && dut.count_q == 0)) else $error("pop while empty");
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge; outputs are compared 1 time unit later.
  task automatic drive(input logic fl, input logic v, input logic [31:0] pc,
                       input logic [31:0] inst, input logic rdy);
    @(negedge clk_i);
    flush_i    = fl;
    if_valid_i = v;
    ifToId_i   = '{pc: pc, inst: inst};
    id_ready_i = rdy;
    #1;
  endtask

  typedef struct {
    logic        fl, v, rdy;
    logic [31:0] pc, inst;
    logic        ev, er, chk;
    logic [31:0] epc, einst;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // single push/pop, then back-pressure with a refused third push
    vecs[0] = '{0, 0, 1, 32'h0,        32'h0,   0, 1, 1, 32'h0,        32'h0};
    vecs[1] = '{0, 1, 1, 32'h80000000, 32'h413, 0, 1, 1, 32'h0,        32'h0};
    vecs[2] = '{0, 0, 1, 32'h0,        32'h0,   1, 1, 1, 32'h80000000, 32'h413};
    vecs[3] = '{0, 0, 1, 32'h0,        32'h0,   0, 1, 1, 32'h0,        32'h0};
    vecs[4] = '{0, 1, 0, 32'h80000000, 32'h1,   0, 1, 0, 32'h0,        32'h0};
    vecs[5] = '{0, 1, 0, 32'h80000004, 32'h2,   1, 1, 1, 32'h80000000, 32'h1};
    vecs[6] = '{0, 1, 0, 32'h80000008, 32'h3,   1, 0, 1, 32'h80000000, 32'h1};
    vecs[7] = '{0, 0, 1, 32'h0,        32'h0,   1, 0, 1, 32'h80000000, 32'h1};
    vecs[8] = '{0, 0, 1, 32'h0,        32'h0,   1, 1, 1, 32'h80000004, 32'h2};
    vecs[9] = '{0, 0, 1, 32'h0,        32'h0,   0, 1, 0, 32'h0,        32'h0};

    rst_i = 1'b1; flush_i = 0; if_valid_i = 0; ifToId_i = '0; id_ready_i = 0;
    #12 rst_i = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].fl, vecs[i].v, vecs[i].pc, vecs[i].inst, vecs[i].rdy);
      check($sformatf("vec%0d id_valid", i), 64'(id_valid_o), 64'(vecs[i].ev));
      check($sformatf("vec%0d if_ready", i), 64'(if_ready_o), 64'(vecs[i].er));
      if (vecs[i].chk)
        check($sformatf("vec%0d head", i), ifToId_o, {vecs[i].epc, vecs[i].einst});
    end

    // streaming: 10 packets back-to-back, each appearing one cycle after it is offered
    for (int c = 0; c <= 10; c++) begin
      drive(0, c < 10, 32'h80000000 + 32'(4 * c), 32'(c), 1);
      check($sformatf("stream%0d id_valid", c), 64'(id_valid_o), 64'(c > 0));
      check($sformatf("stream%0d if_ready", c), 64'(if_ready_o), 64'(1));
      if (c > 0)
        check($sformatf("stream%0d head", c), ifToId_o,
              {32'h80000000 + 32'(4 * (c - 1)), 32'(c - 1)});
    end
    drive(0, 0, 0, 0, 1);
    check("stream_end id_valid", 64'(id_valid_o), 64'(0));

    // flush while full with a packet offered
    drive(0, 1, 32'h80000004, 32'h11, 0);
    drive(0, 1, 32'h80000008, 32'h12, 0);
    drive(1, 1, 32'h8000000C, 32'h13, 1);
    check("flush same-cycle id_valid", 64'(id_valid_o), 64'(0));
    check("flush same-cycle if_ready", 64'(if_ready_o), 64'(0));
    drive(0, 0, 0, 0, 1);
    check("post-flush id_valid", 64'(id_valid_o), 64'(0));
    check("post-flush if_ready", 64'(if_ready_o), 64'(1));
    drive(0, 1, 32'h80000100, 32'h21, 1);
    check("post-flush push id_valid", 64'(id_valid_o), 64'(0));
    drive(0, 0, 0, 0, 1);
    check("post-flush deliver id_valid", 64'(id_valid_o), 64'(1));
    check("post-flush deliver head", ifToId_o, {32'h80000100, 32'h21});
    drive(0, 0, 0, 0, 1);
    check("post-flush drained", 64'(id_valid_o), 64'(0));

    // async reset with count=1, rd_ptr=1, asserted between clock edges
    drive(0, 1, 32'h80000200, 32'h31, 0);
    drive(0, 0, 0, 0, 0);
    check("pre-reset id_valid", 64'(id_valid_o), 64'(1));
    check("pre-reset head", ifToId_o, {32'h80000200, 32'h31});
    rst_i = 1'b1;
    #1;
    check("async reset id_valid", 64'(id_valid_o), 64'(0));
    check("async reset if_ready", 64'(if_ready_o), 64'(1));
    check("async reset head", ifToId_o, 64'(0));
    #1 rst_i = 1'b0;
    drive(0, 1, 32'h80000000, 32'h41, 1);
    check("post-reset push id_valid", 64'(id_valid_o), 64'(0));
    drive(0, 0, 0, 0, 1);
    check("post-reset deliver id_valid", 64'(id_valid_o), 64'(1));
    check("post-reset deliver head", ifToId_o, {32'h80000000, 32'h41});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
